pulse_handshake_tx: RTL and testbench
=====================================

// Module: pulse_handshake_tx
// PURPOSE
//  Source-side half of the pulse-crossing path: turns single-cycle event
//  pulses in the local clk domain into a 4-phase req/ack level handshake
//  toward a receiver in another domain. The receiver's ack is asynchronous,
//  so it passes through an internal flop synchronizer. A saturating pending
//  counter queues pulses that arrive during a transfer. An optional ack
//  timeout flags a stuck receiver.
// PARAMETERS
//  SYNC_STAGES  2   flops in ack synchronizer (>=2)
//  PEND_W       3   pending-counter width; max queued = 2**PEND_W-1
//  TIMEOUT      64  cycles in REQ_HI without ack before err; 0 = disabled
// PORTS
//  clk         in   1       single clock, rising edge
//  rst         in   1       synchronous, active-high reset
//  pulse_in    in   1       event request, 1-cycle pulse, clk domain
//  ack_async   in   1       receiver ack level, asynchronous to clk
//  req_out     out  1       registered request level to receiver
//  busy        out  1       1 when state != IDLE
//  done_pulse  out  1       1-cycle: ack seen for current req
//  drop_pulse  out  1       1-cycle: pulse_in lost, counter saturated
//  err_pulse   out  1       1-cycle: ack timeout expired
//  pending     out  PEND_W  queued events not yet started
// BEHAVIOUR
//  Reset: state=IDLE; req_out, busy, done/drop/err_pulse, pending = 0;
//   synchronizer flops and timeout counter = 0. Reset mid-transfer drops
//   req_out on the next edge and discards queued events.
//  ack_s = last synchronizer stage. No other logic samples ack_async.
//  FSM (registered, one transition per edge):
//   IDLE   : start if pulse_in | pending!=0 -> REQ_HI; req_out=1 next cycle.
//   REQ_HI : req_out=1. ack_s=1 -> REQ_LO, done_pulse=1 this cycle.
//            TIMEOUT!=0 and tcnt==TIMEOUT-1 without ack -> REQ_LO,
//            err_pulse=1, no done_pulse. tcnt clears on REQ_HI entry.
//   REQ_LO : req_out=0. ack_s=0 -> IDLE. No timeout here.
//   REQ_LO always returns through IDLE, so at least 1 idle cycle separates
//   requests. Ack already high at REQ_HI entry completes immediately.
//  Latency: pulse_in at edge N in IDLE with pending=0 -> req_out=1 after N+1.
//   ack_async rise -> done_pulse after SYNC_STAGES edges; req_out low 1 later.
//  Pending counter (start = IDLE->REQ_HI transition):
//   - start from pending=0 on pulse_in: pulse consumed, pending stays 0.
//   - start from pending>0: pending-1, +1 if pulse_in same cycle.
//   - pulse_in while busy: pending+1. At max, pending holds and
//     drop_pulse=1.
//   - Simultaneous decrement and pulse_in at max: net unchanged, no drop.
//  busy is combinational from the state register.
//  pending is the counter register value.
// TESTING  (receiver model: ack_async = req_out delayed 3 clk, SYNC_STAGES=2)
//  1. Single pulse_in at cycle 10 -> req_out 1 at 11; done_pulse once; req_out
//     0 one cycle after done; busy 0 after ack falls; pending 0 throughout.
//  2. pulse_in at 10, 12, 14 -> pending 0,1,2; exactly 3 req_out high phases,
//     3 done_pulses, pending ends 0, no drop_pulse.
//  3. PEND_W=2, 5 pulses while busy -> pending saturates at 3,
//     drop_pulse x2, 4 transfers total.
//  4. ack_async tied 0, TIMEOUT=8 -> req_out high 8 cycles, err_pulse once,
//     no done_pulse, FSM returns to IDLE; queued pulse then retried.
//  5. rst=1 while REQ_HI with pending=2 -> next edge: req_out=0, busy=0,
//     pending=0, all pulses 0.
//  6. ack_async glitch shorter than 1 clk in REQ_HI, no req -> no protocol
//     violation; done_pulse at most once per req.

Source files
------------

// File: rtl/pulse_handshake_tx.sv
// -----------------------------------------------------------------------------
// pulse_handshake_tx
//
// Source-side half of a pulse clock-domain crossing. Single-cycle event pulses
// in the local clk domain are turned into a 4-phase req/ack level handshake
// toward a receiver running on an unrelated clock:
//
//   req_out 0->1, wait ack 1, req_out 1->0, wait ack 0, back to idle.
//
// The receiver's ack arrives asynchronously and is brought into the clk domain
// by a SYNC_STAGES-deep flop synchronizer. Only the last synchronizer stage
// (ack_s) is used by any logic.
//
// Events that arrive while a transfer is in flight are queued in a saturating
// pending counter. When the counter is already full, a further event is
// discarded and reported on drop_pulse. An optional ack timeout abandons a
// request whose ack never arrives and reports it on err_pulse.
//
// Parameters
//   SYNC_STAGES  flops in the ack synchronizer (must be >= 2)
//   PEND_W       pending-counter width; at most 2**PEND_W-1 events queue
//   TIMEOUT      cycles in REQ_HI without ack before err_pulse; 0 disables
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   pulse_in     in   single-cycle event request (clk domain)
//   ack_async    in   receiver ack level, asynchronous to clk
//   req_out      out  registered request level to the receiver
//   busy         out  high whenever the FSM is not in IDLE
//   done_pulse   out  one cycle: ack seen for the current request
//   drop_pulse   out  one cycle: pulse_in lost, pending counter full
//   err_pulse    out  one cycle: ack timeout expired
//   pending      out  queued events not yet started
// -----------------------------------------------------------------------------
module pulse_handshake_tx #(
  parameter int SYNC_STAGES = 2,
  parameter int PEND_W      = 3,
  parameter int TIMEOUT     = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_in,
  input  logic              ack_async,
  output logic              req_out,
  output logic              busy,
  output logic              done_pulse,
  output logic              drop_pulse,
  output logic              err_pulse,
  output logic [PEND_W-1:0] pending
);

  // ---------------------------------------------------------------------------
  // Local constants
  // ---------------------------------------------------------------------------
  // The timeout counter only ever has to hold 0..TIMEOUT-1. A disabled
  // timeout still gets a one-bit counter so that every width stays legal.
  localparam int TCNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TCNT_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TCNT_LAST_I);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    REQ_LO = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Registers and their next-state values
  // ---------------------------------------------------------------------------
  state_e                 state_q, state_d;
  logic                   req_q,   req_d;
  logic [PEND_W-1:0]      pend_q,  pend_d;
  logic [TCNT_W-1:0]      tcnt_q,  tcnt_d;
  logic [SYNC_STAGES-1:0] ack_sync_q;

  // ---------------------------------------------------------------------------
  // Decoded conditions
  // ---------------------------------------------------------------------------
  logic ack_s;        // synchronized ack, the only view of ack_async
  logic start;        // IDLE -> REQ_HI this cycle
  logic timeout_hit;  // last permitted REQ_HI cycle without ack
  logic drop;

  // ---------------------------------------------------------------------------
  // Ack synchronizer
  // ---------------------------------------------------------------------------
  // The first flop may go metastable; the following stages give it time to
  // resolve before anything downstream looks at it.
  // NOTE: synchronizer flops are reset like any other state, so no stale ack
  // level survives a reset and completes the first request after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_async};
    end
  end

  assign ack_s = ack_sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Next-state, counter and output decode
  // ---------------------------------------------------------------------------
  assign busy        = (state_q != IDLE);
  assign start       = (state_q == IDLE) && (pulse_in || (pend_q != '0));
  assign timeout_hit = (TIMEOUT != 0) && (tcnt_q == TCNT_LAST);

  always_comb begin
    // NOTE: every signal written here gets a default first, so that no path
    // through the case statements leaves one unassigned and infers a latch.
    state_d    = state_q;
    done_pulse = 1'b0;
    err_pulse  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = REQ_HI;
        end
      end

      REQ_HI: begin
        // A real ack wins over a timeout that expires in the same cycle.
        if (ack_s) begin
          state_d    = REQ_LO;
          done_pulse = 1'b1;
        end else if (timeout_hit) begin
          state_d   = REQ_LO;
          err_pulse = 1'b1;
        end
      end

      REQ_LO: begin
        // Wait for the receiver to release ack. There is no timeout here:
        // a new request must never be raised while ack is still high.
        if (!ack_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // req_out is registered so the receiver sees a glitch-free level. It is
  // high exactly while the FSM sits in REQ_HI.
  assign req_d = (state_d == REQ_HI);

  // The timeout counter runs only in REQ_HI. It holds zero everywhere else,
  // so it is already clear on REQ_HI entry.
  always_comb begin
    tcnt_d = '0;
    if ((TIMEOUT != 0) && (state_q == REQ_HI)) begin
      tcnt_d = tcnt_q + TCNT_W'(1);
    end
  end

  // Pending counter. A start that begins from an empty queue consumes the
  // pulse that triggered it directly. A start from a non-empty queue takes
  // the oldest queued event and queues the new pulse, if there is one. That
  // is a net no-op when the counter is full, so nothing is dropped then.
  always_comb begin
    pend_d = pend_q;
    drop   = 1'b0;

    if (start) begin
      if (pend_q != '0) begin
        pend_d = pend_q - PEND_W'(1) + PEND_W'(pulse_in);
      end
    end else if (pulse_in && busy) begin
      if (pend_q == PEND_MAX) begin
        drop = 1'b1;
      end else begin
        pend_d = pend_q + PEND_W'(1);
      end
    end
  end

  assign drop_pulse = drop;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated only with non-blocking assignments, so
  // every flop samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      pend_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      pend_q  <= pend_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign req_out = req_q;
  assign pending = pend_q;

endmodule

// File: tb/tb_pulse_handshake_tx.sv
// -----------------------------------------------------------------------------
// tb_pulse_handshake_tx
//
// Directed bench for pulse_handshake_tx with SYNC_STAGES=2, PEND_W=2 and
// TIMEOUT=8. The receiver model returns req_out as ack_async three clk cycles
// later. It can be disabled, which ties ack low, and a glitch can be ORed
// onto ack.
//
// Timing: inputs change 1 time unit after a rising edge. Outputs are sampled
// on the falling edge.
// -----------------------------------------------------------------------------
module tb_pulse_handshake_tx;

  localparam int PEND_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              pulse_in;
  logic              ack_async;
  logic              req_out;
  logic              busy;
  logic              done_pulse;
  logic              drop_pulse;
  logic              err_pulse;
  logic [PEND_W-1:0] pending;

  pulse_handshake_tx #(
    .SYNC_STAGES(2),
    .PEND_W     (PEND_W),
    .TIMEOUT    (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pulse_in  (pulse_in),
    .ack_async (ack_async),
    .req_out   (req_out),
    .busy      (busy),
    .done_pulse(done_pulse),
    .drop_pulse(drop_pulse),
    .err_pulse (err_pulse),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  // Receiver model: ack = req delayed 3 clk, plus an optional glitch.
  logic       rx_en;
  logic       glitch;
  logic [2:0] rx_pipe = '0;

  always @(posedge clk) rx_pipe <= {rx_pipe[1:0], rx_en & req_out};
  assign ack_async = rx_pipe[2] | glitch;

  // Event monitor. It counts pulses, req rising edges, and any request that
  // produced more than one done_pulse.
  logic mon_clr;
  int   n_done = 0, n_drop = 0, n_err = 0, n_req = 0, n_viol = 0;
  logic req_prev = 1'b0;
  logic done_this_req = 1'b0;

  always @(negedge clk) begin
    if (mon_clr) begin
      n_done <= 0; n_drop <= 0; n_err <= 0; n_req <= 0; n_viol <= 0;
      done_this_req <= 1'b0;
    end else begin
      if (done_pulse) n_done <= n_done + 1;
      if (drop_pulse) n_drop <= n_drop + 1;
      if (err_pulse)  n_err  <= n_err + 1;
      if (req_out && !req_prev) begin
        n_req         <= n_req + 1;
        done_this_req <= done_pulse;
      end else if (done_pulse) begin
        if (done_this_req) n_viol <= n_viol + 1;
        done_this_req <= 1'b1;
      end
    end
    req_prev <= req_out;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock cycle. Drive pulse_in for the next edge, then stop at the
  // falling edge so the outputs can be sampled.
  task automatic cyc(input logic p);
    @(posedge clk);
    #1 pulse_in = p;
    @(negedge clk);
  endtask

  task automatic cycs(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0);
  endtask

  task automatic clear_mon();
    @(posedge clk);
    #1 mon_clr = 1'b1;
    @(posedge clk);
    #1 mon_clr = 1'b0;
    @(negedge clk);
  endtask

  // Wait, with a cycle budget, until the DUT is idle and the queue is empty.
  task automatic wait_idle(input string tag, input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (!busy && pending == '0) ok = 1'b1;
    end
    check(tag, ok, 1);
    cycs(4);  // let the receiver pipe drain
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; pulse_in = 1'b0; rx_en = 1'b1; glitch = 1'b0; mon_clr = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req",     req_out,    0);
    check("rst_busy",    busy,       0);
    check("rst_pending", pending,    0);
    check("rst_pulses",  {done_pulse, drop_pulse, err_pulse}, 0);
    @(posedge clk); #1 rst = 1'b0; mon_clr = 1'b0;
    cycs(5);

    // ---- 1: single transfer, cycle-exact ----
    clear_mon();
    cyc(1'b1);                                                     // pulse for E0
    cyc(1'b0); check("t1_req_rise", req_out, 1); check("t1_busy", busy, 1);
                check("t1_pend0", pending, 0);                     // after E0
    cycs(4);   check("t1_no_done_e4", done_pulse, 0);              // after E4
    cyc(1'b0); check("t1_done_e5", done_pulse, 1);
                check("t1_req_e5", req_out, 1);                    // after E5
    cyc(1'b0); check("t1_req_fall", req_out, 0); check("t1_done_off", done_pulse, 0);
                check("t1_busy_lo", busy, 1);                      // after E6
    cycs(5);   check("t1_busy_e11", busy, 1);                      // after E11
    cyc(1'b0); check("t1_idle_e12", busy, 0); check("t1_pend_end", pending, 0);
    cycs(4);
    check("t1_n_done", n_done, 1);
    check("t1_n_req",  n_req,  1);

    // ---- 2: three spaced pulses ----
    clear_mon();
    cyc(1'b1);
    cyc(1'b0); check("t2_pend_a", pending, 0);
    cyc(1'b1);
    cyc(1'b0); check("t2_pend_b", pending, 1);
    cyc(1'b1);
    cyc(1'b0); check("t2_pend_c", pending, 2);
    wait_idle("t2_finish", 200);
    check("t2_n_req",  n_req,  3);
    check("t2_n_done", n_done, 3);
    check("t2_n_drop", n_drop, 0);

    // ---- 3: saturation with PEND_W=2 ----
    clear_mon();
    cyc(1'b1);                                                     // starts transfer
    cyc(1'b1); check("t3_pend0", pending, 0); check("t3_drop0", drop_pulse, 0);
    cyc(1'b1); check("t3_pend1", pending, 1);
    cyc(1'b1); check("t3_pend2", pending, 2);
    cyc(1'b1); check("t3_pend3", pending, 3); check("t3_drop_a", drop_pulse, 1);
    cyc(1'b1); check("t3_pend3b", pending, 3); check("t3_drop_b", drop_pulse, 1);
    cyc(1'b0); check("t3_pend3c", pending, 3); check("t3_drop_off", drop_pulse, 0);
    wait_idle("t3_finish", 400);
    check("t3_n_req",  n_req,  4);
    check("t3_n_done", n_done, 4);
    check("t3_n_drop", n_drop, 2);

    // ---- 4: ack stuck low, timeout, then retry of the queued pulse ----
    clear_mon();
    rx_en = 1'b0;
    cyc(1'b1);                                                     // pulse for E0
    cyc(1'b1); check("t4_req", req_out, 1);                        // after E0, pulse E1
    cyc(1'b0); check("t4_pend1", pending, 1);                      // after E1
    cycs(5);   check("t4_no_err_e6", err_pulse, 0); check("t4_req_e6", req_out, 1);
    cyc(1'b0); check("t4_err_e7", err_pulse, 1); check("t4_req_e7", req_out, 1);
    cyc(1'b0); check("t4_req_off", req_out, 0); check("t4_err_off", err_pulse, 0);
                check("t4_busy_lo", busy, 1);                      // after E8
    rx_en = 1'b1;
    cyc(1'b0); check("t4_idle", busy, 0); check("t4_pend_idle", pending, 1);
    cyc(1'b0); check("t4_retry", req_out, 1); check("t4_pend_retry", pending, 0);
    wait_idle("t4_finish", 200);
    check("t4_n_err",  n_err,  1);
    check("t4_n_done", n_done, 1);
    check("t4_n_req",  n_req,  2);

    // ---- 5: reset mid-transfer with pending=2 ----
    cyc(1'b1);
    cyc(1'b1);
    cyc(1'b1);
    cyc(1'b0); check("t5_pend2", pending, 2); check("t5_req_pre", req_out, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("t5_req",     req_out, 0);
    check("t5_busy",    busy,    0);
    check("t5_pending", pending, 0);
    check("t5_pulses",  {done_pulse, drop_pulse, err_pulse}, 0);
    @(posedge clk); #1 rst = 1'b0;
    cycs(8);

    // ---- 6: short ack glitches ----
    clear_mon();
    rx_en = 1'b0;
    @(posedge clk); #1 glitch = 1'b1; #3 glitch = 1'b0;            // idle, between edges
    cycs(4);
    check("t6_idle_busy", busy, 0);
    cyc(1'b1);
    cyc(1'b0); check("t6_req", req_out, 1);                        // after E0
    @(posedge clk); #1 glitch = 1'b1; #3 glitch = 1'b0;            // between edges
    @(negedge clk);
    check("t6_no_done", done_pulse, 0); check("t6_busy", busy, 1);
    #3 glitch = 1'b1; #4 glitch = 1'b0;                            // straddles E2
    wait_idle("t6_finish", 100);
    check("t6_n_done", n_done, 1);
    check("t6_n_err",  n_err,  0);
    check("t6_viol",   n_viol, 0);
    rx_en = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
